// File: rtl/ldpc_pkg.sv
// Shared types and constants for the LDPC decode scheduler.
// Provides the phase enum, array geometry and the one-hot select helper.
package ldpc_pkg;

    localparam int unsigned L          = 32;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned K          = 6;
    localparam int unsigned ITER_WIDTH = 5;
    localparam int unsigned PIPE_LAT   = 4;

    localparam int unsigned NPE       = K * K;
    localparam int unsigned PH_LEN    = L + PIPE_LAT;
    localparam int unsigned CNT_WIDTH = $clog2(PH_LEN);
    localparam int unsigned IDX_WIDTH = $clog2(NPE);
    localparam int unsigned RC_WIDTH  = $clog2(K);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CNP,
        VNP,
        READ
    } state_e;

    function automatic logic [NPE-1:0] onehot(input logic [IDX_WIDTH-1:0] idx);
        onehot = NPE'(1) << idx;
    endfunction

endpackage

// File: rtl/ldpc_decode_scheduler_if.sv
// Control/data handshake bundle between the scheduler and its host/decoder.
// slave = scheduler side, master = host side.
interface ldpc_decode_scheduler_if;
    import ldpc_pkg::*;

    logic                  start;
    logic [ITER_WIDTH-1:0] max_iter;
    logic                  in_valid;
    logic                  in_ready;
    logic                  syndrome_ok;
    logic                  en;
    logic                  f_id;
    logic                  relay;
    logic [K-1:0]          column_select;
    logic [NPE-1:0]        pe_select;
    logic [ADDR_WIDTH-1:0] load_add;
    logic [ADDR_WIDTH-1:0] read_add;
    logic                  out_valid;
    logic                  busy;
    logic                  done;
    logic [ITER_WIDTH-1:0] iter_count;

    modport slave (
        input  start, max_iter, in_valid, syndrome_ok,
        output in_ready, en, f_id, relay, column_select, pe_select,
               load_add, read_add, out_valid, busy, done, iter_count
    );

    modport master (
        output start, max_iter, in_valid, syndrome_ok,
        input  in_ready, en, f_id, relay, column_select, pe_select,
               load_add, read_add, out_valid, busy, done, iter_count
    );

endinterface

// File: rtl/ldpc_phase_counter.sv
// Per-phase address sequencer: read address 0..L-1, then held at L-1 for the drain.
// last_o marks the final address cycle, term_o the final drain cycle.
module ldpc_phase_counter
    import ldpc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr_i,
    input  logic                  en_i,
    output logic [ADDR_WIDTH-1:0] read_add_o,
    output logic                  last_o,
    output logic                  term_o
);

    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  last_q, last_d;
    logic                  term_q, term_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
        addr_d = (cnt_d >= CNT_WIDTH'(L)) ? ADDR_WIDTH'(L - 1) : ADDR_WIDTH'(cnt_d);
        last_d = (cnt_d == CNT_WIDTH'(L - 1));
        term_d = (cnt_d == CNT_WIDTH'(PH_LEN - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            addr_q <= '0;
            last_q <= 1'b0;
            term_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            last_q <= last_d;
            term_q <= term_d;
        end
    end

    assign read_add_o = addr_q;
    assign last_o     = last_q;
    assign term_o     = term_q;

endmodule

// File: rtl/ldpc_decode_scheduler.sv
// LDPC decoder sequencer: intrinsic load, alternating CNP/VNP iterations with
// early stop on zero syndrome, then bit readout.
module ldpc_decode_scheduler
    import ldpc_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    ldpc_decode_scheduler_if.slave  bus
);

    state_e state_q, state_d;

    logic [ITER_WIDTH-1:0] max_iter_q, max_iter_d;
    logic [ITER_WIDTH-1:0] iter_q, iter_d;
    logic [ITER_WIDTH-1:0] iter_inc;
    logic [ADDR_WIDTH-1:0] load_add_q, load_add_d;
    logic [RC_WIDTH-1:0]   row_q, row_d, col_q, col_d;
    logic [NPE-1:0]        pe_sel_q, pe_sel_d;
    logic [K-1:0]          col_sel_q, col_sel_d;
    logic en_q, en_d, f_id_q, f_id_d, relay_q, relay_d;
    logic out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;

    logic                  beat, last_beat, load_wrap;
    logic                  ph_clr, ph_en, ph_last, ph_term;
    logic [ADDR_WIDTH-1:0] read_add;

    assign beat      = (state_q == LOAD) && bus.in_valid;
    assign load_wrap = (load_add_q == ADDR_WIDTH'(L - 1));
    assign last_beat = beat && load_wrap && (row_q == RC_WIDTH'(K - 1))
                       && (col_q == RC_WIDTH'(K - 1));
    assign iter_inc  = iter_q + ITER_WIDTH'(1);

    assign ph_clr = (state_d != state_q);
    assign ph_en  = (state_q == CNP) || (state_q == VNP) || (state_q == READ);

    ldpc_phase_counter u_phase (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (ph_clr),
        .en_i       (ph_en),
        .read_add_o (read_add),
        .last_o     (ph_last),
        .term_o     (ph_term)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Early stop needs at least one completed iteration; syndrome is looked at only on the CNP drain end.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = LOAD;
            LOAD: if (last_beat) state_d = CNP;
            CNP:  if (ph_term)   state_d = (bus.syndrome_ok && (iter_q != '0)) ? READ : VNP;
            VNP:  if (ph_term)   state_d = (iter_inc == max_iter_q) ? READ : CNP;
            READ: if (ph_last)   state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_comb begin
        max_iter_d = max_iter_q;
        iter_d     = iter_q;
        load_add_d = load_add_q;
        row_d      = row_q;
        col_d      = col_q;
        if ((state_q == IDLE) && bus.start) begin
            max_iter_d = (bus.max_iter == '0) ? ITER_WIDTH'(1) : bus.max_iter;
            iter_d     = '0;
            load_add_d = '0;
            row_d      = '0;
            col_d      = '0;
        end else if (beat) begin
            load_add_d = load_wrap ? '0 : load_add_q + ADDR_WIDTH'(1);
            if (load_wrap) begin
                row_d = (row_q == RC_WIDTH'(K - 1)) ? '0 : row_q + RC_WIDTH'(1);
                col_d = (row_q == RC_WIDTH'(K - 1)) ? col_q + RC_WIDTH'(1) : col_q;
            end
        end else if ((state_q == VNP) && ph_term) begin
            iter_d = iter_inc;
        end

        pe_sel_d    = '0;
        col_sel_d   = '0;
        if (state_d == LOAD) begin
            pe_sel_d  = onehot(IDX_WIDTH'(row_d) + IDX_WIDTH'(col_d) * IDX_WIDTH'(K));
            col_sel_d = K'(onehot(IDX_WIDTH'(col_d)));
        end
        en_d        = (state_d == CNP) || (state_d == VNP) || (state_d == READ);
        relay_d     = (state_d == VNP) || (state_d == READ);
        out_valid_d = (state_d == READ);
        busy_d      = (state_d != IDLE);
        done_d      = (state_q == READ) && (state_d == IDLE);
        f_id_d      = ((state_d == CNP) || (state_d == VNP)) && (iter_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            max_iter_q  <= '0;
            iter_q      <= '0;
            load_add_q  <= '0;
            row_q       <= '0;
            col_q       <= '0;
            pe_sel_q    <= '0;
            col_sel_q   <= '0;
            en_q        <= 1'b0;
            f_id_q      <= 1'b0;
            relay_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            max_iter_q  <= max_iter_d;
            iter_q      <= iter_d;
            load_add_q  <= load_add_d;
            row_q       <= row_d;
            col_q       <= col_d;
            pe_sel_q    <= pe_sel_d;
            col_sel_q   <= col_sel_d;
            en_q        <= en_d;
            f_id_q      <= f_id_d;
            relay_q     <= relay_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.in_ready      = (state_q == LOAD);
    assign bus.en            = en_q;
    assign bus.f_id          = f_id_q;
    assign bus.relay         = relay_q;
    assign bus.column_select = col_sel_q;
    assign bus.pe_select     = pe_sel_q;
    assign bus.load_add      = load_add_q;
    assign bus.read_add      = read_add;
    assign bus.out_valid     = out_valid_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.iter_count    = iter_q;

endmodule

// File: tb/tb_ldpc_decode_scheduler.sv
// Self-checking bench for ldpc_decode_scheduler: frame table plus reset-in-VNP sequence.
module tb_ldpc_decode_scheduler;
    import ldpc_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ldpc_decode_scheduler_if bus ();

    ldpc_decode_scheduler dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int max_iter;
        int syn_cnp;
        int gap_pct;
        bit start_in_read;
        int exp_iter;
        int exp_cnp;
        int exp_vnp;
    } vec_t;

    vec_t vecs [5];
    int   checks = 0;
    int   errors = 0;
    int   rd_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic start_frame(input int m);
        bus.max_iter = ITER_WIDTH'(m);
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
    endtask

    task automatic do_load(input int gap_pct, input bit do_check);
        int b = 0;
        int cyc = 0;
        int pe;
        logic v;
        logic [63:0] pe_exp;
        logic [63:0] col_exp;
        while (b < int'(NPE * L) && cyc < 20000) begin
            v = ($urandom_range(0, 99) >= gap_pct);
            if (do_check) begin
                pe      = b / int'(L);
                pe_exp  = 64'(1) << pe;
                col_exp = 64'(1) << (pe / int'(K));
                chk("in_ready", 64'(bus.in_ready), 64'(1));
                chk("load_add", 64'(bus.load_add), 64'(b % int'(L)));
                chk("pe_select", 64'(bus.pe_select), pe_exp);
                chk("column_select", 64'(bus.column_select), col_exp);
            end
            bus.in_valid = v;
            if (v && bus.in_ready) b++;
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (b != int'(NPE * L)) begin
            checks++;
            errors++;
            $display("FAIL load_timeout: beats %0d expected %0d", b, NPE * L);
        end
    endtask

    task automatic run_frame(input vec_t v);
        int  kind;
        int  prev = 0, run = 0, cnp_n = 0, vnp_n = 0, cnp_ph = 0, fid_n = 0, cyc = 0;
        bit  done_seen = 0;
        start_frame(v.max_iter);
        do_load(v.gap_pct, 1'b1);
        chk("cnp_entry_en", 64'(bus.en), 64'(1));
        chk("cnp_entry_relay", 64'(bus.relay), 64'(0));
        chk("cnp_entry_in_ready", 64'(bus.in_ready), 64'(0));
        chk("cnp_entry_pe_select", 64'(bus.pe_select), 64'(0));
        for (int i = 0; i < int'(L); i++) rd_q.push_back(i);
        while (!done_seen && cyc < 3000) begin
            kind = bus.out_valid ? 3 : (bus.en && bus.relay) ? 2 : bus.en ? 1 : 0;
            if (kind != prev) begin
                if (prev == 1 || prev == 2) chk("phase_len", 64'(run), 64'(PH_LEN));
                if (prev == 3) chk("read_len", 64'(run), 64'(L));
                if (kind == 1) cnp_ph++;
                run = 0;
            end
            run++;
            prev = kind;
            if (kind == 1) cnp_n++;
            if (kind == 2) vnp_n++;
            if (bus.f_id) fid_n++;
            if (kind == 3) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_extra: read_add %0d with no expected entry", bus.read_add);
                end else begin
                    chk("read_add", 64'(bus.read_add), 64'(rd_q.pop_front()));
                end
            end
            if (kind == 1 && run == int'(PH_LEN)) bus.syndrome_ok = (cnp_ph == v.syn_cnp);
            else bus.syndrome_ok = 1'($urandom_range(0, 1));
            if (bus.done) begin
                done_seen = 1;
                chk("done_iter_count", 64'(bus.iter_count), 64'(v.exp_iter));
                chk("done_out_valid", 64'(bus.out_valid), 64'(0));
                chk("done_busy", 64'(bus.busy), 64'(0));
                chk("done_en", 64'(bus.en), 64'(0));
            end
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.start    = v.start_in_read && bus.out_valid;
            step();
            cyc++;
        end
        if (!done_seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done after %0d cycles", cyc);
        end
        bus.in_valid    = 1'b0;
        bus.syndrome_ok = 1'b0;
        bus.start       = 1'b0;
        chk("done_pulse_width", 64'(bus.done), 64'(0));
        chk("cnp_cycles", 64'(cnp_n), 64'(v.exp_cnp * int'(PH_LEN)));
        chk("vnp_cycles", 64'(vnp_n), 64'(v.exp_vnp * int'(PH_LEN)));
        chk("f_id_cycles", 64'(fid_n), 64'(2 * PH_LEN));
        chk("read_remaining", 64'(rd_q.size()), 64'(0));
        rd_q.delete();
        step();
        step();
        chk("idle_busy", 64'(bus.busy), 64'(0));
        chk("idle_iter_held", 64'(bus.iter_count), 64'(v.exp_iter));
        chk("idle_load_add", 64'(bus.load_add), 64'(0));
    endtask

    task automatic reset_in_vnp();
        int  vnp_starts = 0;
        int  cyc = 0;
        bit  in_vnp = 0;
        bit  cur;
        start_frame(3);
        do_load(0, 1'b0);
        while (vnp_starts < 2 && cyc < 500) begin
            cur = bus.en && bus.relay && !bus.out_valid;
            if (cur && !in_vnp) vnp_starts++;
            in_vnp = cur;
            if (vnp_starts < 2) begin
                step();
                cyc++;
            end
        end
        step();
        step();
        chk("pre_reset_relay", 64'(bus.relay), 64'(1));
        chk("pre_reset_iter", 64'(bus.iter_count), 64'(1));
        reset_n = 1'b0;
        step();
        chk("rst_en", 64'(bus.en), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_iter", 64'(bus.iter_count), 64'(0));
        chk("rst_relay", 64'(bus.relay), 64'(0));
        chk("rst_f_id", 64'(bus.f_id), 64'(0));
        chk("rst_read_add", 64'(bus.read_add), 64'(0));
        chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
        reset_n = 1'b1;
        step();
        chk("post_rst_busy", 64'(bus.busy), 64'(0));
        chk("post_rst_en", 64'(bus.en), 64'(0));
    endtask

    initial begin
        vecs[0] = '{3, 0, 0,  1'b0, 3, 3, 3};
        vecs[1] = '{5, 2, 30, 1'b0, 1, 2, 1};
        vecs[2] = '{0, 0, 0,  1'b1, 1, 1, 1};
        vecs[3] = '{2, 1, 20, 1'b0, 2, 2, 2};
        vecs[4] = '{4, 3, 0,  1'b0, 2, 3, 2};

        reset_n         = 1'b0;
        bus.start       = 1'b0;
        bus.max_iter    = '0;
        bus.in_valid    = 1'b0;
        bus.syndrome_ok = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("reset_busy", 64'(bus.busy), 64'(0));
        chk("reset_en", 64'(bus.en), 64'(0));
        chk("reset_in_ready", 64'(bus.in_ready), 64'(0));
        chk("reset_pe_select", 64'(bus.pe_select), 64'(0));
        chk("reset_iter", 64'(bus.iter_count), 64'(0));
        chk("reset_done", 64'(bus.done), 64'(0));

        // in_valid while idle must not move the load address
        bus.in_valid = 1'b1;
        repeat (3) step();
        bus.in_valid = 1'b0;
        chk("idle_in_valid_load_add", 64'(bus.load_add), 64'(0));

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);
        reset_in_vnp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
